interrupt_pending_arbiter: RTL

- Sits directly downstream of the interrupt edge detector.
- Latches its one-cycle request pulses into a pending register and masks them with per-source enables.
- Selects one winner and presents it to the core through an irq / claim / complete handshake.
- Non-nested: at most one interrupt is in service at a time.

---
 rtl/interrupt_pkg.sv | 22 ++
 rtl/interrupt_priority_select.sv | 41 ++++
 rtl/interrupt_pending_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/interrupt_pkg.sv
// Shared types and constants for the interrupt pending arbiter.
package interrupt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Width of an interrupt ID; a single source still needs one bit.
    function automatic int unsigned id_width(input int unsigned n);
        if (n <= 32'd1) begin
            return 32'd1;
        end
        return unsigned'($clog2(n));
    endfunction

    localparam state_t RST_STATE       = IDLE;
    localparam logic   RST_IRQ         = 1'b0;
    localparam logic   RST_CLAIM_VALID = 1'b0;

endpackage

// File: rtl/interrupt_priority_select.sv
// Find-first-set over an N-bit vector, searching upward from a rotation base and wrapping.
module interrupt_priority_select
    import interrupt_pkg::*;
#(
    parameter int unsigned N    = 32,
    parameter int unsigned ID_W = id_width(N)
) (
    input  logic [N-1:0]    vec,
    input  logic [ID_W-1:0] base,
    output logic            found_c,
    output logic [ID_W-1:0] idx_c
);

    localparam int unsigned SUM_W = ID_W + 1;

    logic [2*N-1:0]  dbl;
    logic [N-1:0]    rot;
    logic [ID_W-1:0] off;
    logic [SUM_W-1:0] sum;

    // Rotate so that bit 0 of rot corresponds to vec[base].
    assign dbl = {vec, vec};
    assign rot = N'(dbl >> base);

    always_comb begin
        found_c = 1'b0;
        off     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found_c = 1'b1;
                off     = ID_W'(i);
            end
        end
        sum = SUM_W'(off) + SUM_W'(base);
        if (sum >= SUM_W'(N)) begin
            sum = sum - SUM_W'(N);
        end
        idx_c = ID_W'(sum);
    end

endmodule

// File: rtl/interrupt_pending_arbiter.sv
// Pending latch, enable masking and non-nested irq/claim/complete handshake.
// Build option: INTERRUPT_ROUND_ROBIN_EN selects round-robin instead of fixed lowest-index priority.
module interrupt_pending_arbiter
    import interrupt_pkg::*;
#(
    parameter  int unsigned N_interrupts = 32,
    localparam int unsigned ID_W         = id_width(N_interrupts)
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [N_interrupts-1:0] interrupt_requests,
    input  logic [N_interrupts-1:0] interrupt_enable,
    input  logic                    claim,
    input  logic                    complete,
    input  logic [ID_W-1:0]         complete_id,
    output logic                    irq,
    output logic [ID_W-1:0]         claim_id,
    output logic                    claim_valid,
    output logic [N_interrupts-1:0] pending
);

    state_t                  state_q, state_d;
    logic [N_interrupts-1:0] pending_q, pending_d;
    logic [ID_W-1:0]         sel_id_q, sel_id_d;
    logic [ID_W-1:0]         last_id_q, last_id_d;
    logic                    irq_q, irq_d;
    logic [ID_W-1:0]         claim_id_q, claim_id_d;
    logic                    claim_valid_q, claim_valid_d;

    logic [N_interrupts-1:0] eligible;
    logic [N_interrupts-1:0] clr_mask;
    logic                    claim_accept;
    logic [ID_W-1:0]         base;
    logic                    win_found_c;
    logic [ID_W-1:0]         win_idx_c;

    assign eligible = pending_q & interrupt_enable;

`ifdef INTERRUPT_ROUND_ROBIN_EN
    assign base = (last_id_q == ID_W'(N_interrupts - 1)) ? '0 : last_id_q + ID_W'(1);
`else
    assign base = '0;
`endif

    interrupt_priority_select #(
        .N    (N_interrupts),
        .ID_W (ID_W)
    ) u_select (
        .vec     (eligible),
        .base    (base),
        .found_c (win_found_c),
        .idx_c   (win_idx_c)
    );

    // Next state, pending update and registered outputs.
    always_comb begin
        state_d       = state_q;
        sel_id_d      = sel_id_q;
        last_id_d     = last_id_q;
        claim_accept  = 1'b0;
        claim_valid_d = 1'b0;
        clr_mask      = '0;

        case (state_q)
            IDLE: begin
                if (win_found_c) begin
                    sel_id_d = win_idx_c;
                    state_d  = PRESENT;
                end
            end
            PRESENT: begin
                // A claim takes precedence over a same-cycle enable drop.
                if (claim) begin
                    claim_accept  = 1'b1;
                    last_id_d     = sel_id_q;
                    claim_valid_d = 1'b1;
                    state_d       = SERVICE;
                end else if (!eligible[sel_id_q]) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (complete && (complete_id == last_id_q)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (claim_accept) begin
            clr_mask[sel_id_q] = 1'b1;
        end
        // New requests win over a same-cycle claim clear.
        pending_d = (pending_q & ~clr_mask) | interrupt_requests;

        irq_d      = (state_d == PRESENT);
        claim_id_d = '0;
        if (state_d == PRESENT) begin
            claim_id_d = sel_id_d;
        end else if (state_d == SERVICE) begin
            claim_id_d = last_id_d;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= RST_STATE;
            pending_q     <= '0;
            sel_id_q      <= '0;
            last_id_q     <= '0;
            irq_q         <= RST_IRQ;
            claim_id_q    <= '0;
            claim_valid_q <= RST_CLAIM_VALID;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            sel_id_q      <= sel_id_d;
            last_id_q     <= last_id_d;
            irq_q         <= irq_d;
            claim_id_q    <= claim_id_d;
            claim_valid_q <= claim_valid_d;
        end
    end

    assign irq         = irq_q;
    assign claim_id    = claim_id_q;
    assign claim_valid = claim_valid_q;
    assign pending     = pending_q;

endmodule
